// File: rtl/lut_m_pkg.sv
// Shared constants and reset-table contents for the programmable address LUT.
// Feature macro: LUT_M_POSTINC_EN enables post-increment on lookup.
package lut_m_pkg;

   localparam int DEF_DEPTH   = 8;
   localparam int DEF_AW      = 8;
   localparam int DEF_PW      = 8;
   localparam int NZ_DEFAULTS = 5;

   // Entry i resets to i+1 for the first NZ_DEFAULTS entries, else 0.
   function automatic int unsigned lut_default(input int unsigned idx);
      if (idx < NZ_DEFAULTS) begin
         return idx + 1;
      end
      return 0;
   endfunction

endpackage

// File: rtl/lut_m_entry.sv
// One table entry: AW-bit register with reset value, write, and
// increment-by-STRIDE where a write always overrides the increment.
module lut_m_entry
   import lut_m_pkg::*;
#(
   parameter int             AW      = DEF_AW,
   parameter logic [AW-1:0]  STRIDE  = 1,
   parameter logic [AW-1:0]  RST_VAL = '0
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          we,
   input  logic [AW-1:0] wd,
   input  logic          inc,
   output logic [AW-1:0] q
);

   always_ff @(posedge clk) begin
      if (reset) begin
         q <= RST_VAL;
      end else if (we) begin
         q <= wd;
      end else if (inc) begin
         q <= q + STRIDE;
      end
   end

endmodule

// File: rtl/lut_m_prog.sv
// Programmable pointer-to-address lookup table with registered output.
// Feature macro: LUT_M_POSTINC_EN enables post-increment on lookup.
module lut_m_prog
   import lut_m_pkg::*;
#(
   parameter int DEPTH  = DEF_DEPTH,
   parameter int AW     = DEF_AW,
   parameter int PW     = DEF_PW,
   parameter int STRIDE = 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          rd_en,
   input  logic [PW-1:0] ptr,
   input  logic          inc,
   input  logic          wr_en,
   input  logic [PW-1:0] wr_ptr,
   input  logic [AW-1:0] wr_data,
   output logic [AW-1:0] dm_adr,
   output logic          adr_vld,
   output logic          ptr_err
);

   localparam logic [31:0]   DEPTH_U  = 32'(DEPTH);
   localparam logic [AW-1:0] STRIDE_W = AW'(STRIDE);

   logic [AW-1:0] q   [DEPTH];
   logic [DEPTH-1:0] we_v;
   logic [DEPTH-1:0] inc_v;
   logic [AW-1:0] rd_val;
   logic          rd_oob;
   logic          inc_q;

`ifdef LUT_M_POSTINC_EN
   assign inc_q = inc;
`else
   logic unused_inc;
   assign unused_inc = inc;
   assign inc_q      = 1'b0;
`endif

   assign rd_oob = 32'(ptr) >= DEPTH_U;

   // Decode write/increment strobes and select the read value.
   always_comb begin
      we_v   = '0;
      inc_v  = '0;
      rd_val = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (wr_en && wr_ptr == PW'(i)) begin
            we_v[i] = 1'b1;
         end
         if (rd_en && inc_q && ptr == PW'(i)) begin
            inc_v[i] = 1'b1;
         end
         if (ptr == PW'(i)) begin
            rd_val = q[i];
         end
      end
   end

   for (genvar g = 0; g < DEPTH; g++) begin : g_ent
      lut_m_entry #(
         .AW      (AW),
         .STRIDE  (STRIDE_W),
         .RST_VAL (AW'(lut_default(g)))
      ) u_ent (
         .clk   (clk),
         .reset (reset),
         .we    (we_v[g]),
         .wd    (wr_data),
         .inc   (inc_v[g]),
         .q     (q[g])
      );
   end

   // Output register samples pre-edge contents: read-before-write.
   always_ff @(posedge clk) begin
      if (reset) begin
         dm_adr  <= '0;
         adr_vld <= 1'b0;
         ptr_err <= 1'b0;
      end else begin
         adr_vld <= rd_en;
         ptr_err <= rd_en && rd_oob;
         if (rd_en) begin
            dm_adr <= rd_oob ? '0 : rd_val;
         end
      end
   end

endmodule

// File: tb/tb_lut_m_prog.sv
// Directed testbench for lut_m_prog (default parameters).
// Honours LUT_M_POSTINC_EN for post-increment expectations.
module tb_lut_m_prog;

   logic       clk = 1'b0;
   logic       reset;
   logic       rd_en;
   logic [7:0] ptr;
   logic       inc;
   logic       wr_en;
   logic [7:0] wr_ptr;
   logic [7:0] wr_data;
   logic [7:0] dm_adr;
   logic       adr_vld;
   logic       ptr_err;

   int vectors = 0;
   int errors  = 0;

   always #5 clk = ~clk;

   lut_m_prog dut (
      .clk     (clk),
      .reset   (reset),
      .rd_en   (rd_en),
      .ptr     (ptr),
      .inc     (inc),
      .wr_en   (wr_en),
      .wr_ptr  (wr_ptr),
      .wr_data (wr_data),
      .dm_adr  (dm_adr),
      .adr_vld (adr_vld),
      .ptr_err (ptr_err)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      rd_en = 0; inc = 0; wr_en = 0;
      ptr = 0; wr_ptr = 0; wr_data = 0;
   endtask

   task automatic test_reset();
      reset = 1; idle();
      rd_en = 1; ptr = 0;
      tick(); tick();
      reset = 0; idle();
      vectors++;
      if ({adr_vld, ptr_err, dm_adr} !== {1'b0, 1'b0, 8'd0}) begin
         errors++;
         $display("FAIL reset: got vld/err/adr %b/%b/%0d expected 0/0/0",
                  adr_vld, ptr_err, dm_adr);
      end
   endtask

   task automatic test_defaults();
      logic [7:0] exp_v [6] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd0};
      for (int i = 0; i < 6; i++) begin
         rd_en = 1; ptr = 8'(i);
         tick();
         vectors++;
         if ({adr_vld, ptr_err, dm_adr} !== {1'b1, 1'b0, exp_v[i]}) begin
            errors++;
            $display("FAIL default[%0d]: got %b/%b/%0d expected 1/0/%0d",
                     i, adr_vld, ptr_err, dm_adr, exp_v[i]);
         end
      end
      idle();
   endtask

   task automatic test_oob();
      rd_en = 1; ptr = 9;
      tick();
      idle();
      vectors++;
      if ({adr_vld, ptr_err, dm_adr} !== {1'b1, 1'b1, 8'd0}) begin
         errors++;
         $display("FAIL oob: got %b/%b/%0d expected 1/1/0",
                  adr_vld, ptr_err, dm_adr);
      end
      tick();
      vectors++;
      if ({adr_vld, ptr_err, dm_adr} !== {1'b0, 1'b0, 8'd0}) begin
         errors++;
         $display("FAIL oob_idle: got %b/%b/%0d expected 0/0/0",
                  adr_vld, ptr_err, dm_adr);
      end
   endtask

   task automatic test_read_before_write();
      rd_en = 1; ptr = 2;
      wr_en = 1; wr_ptr = 2; wr_data = 128;
      tick();
      idle();
      vectors++;
      if ({adr_vld, dm_adr} !== {1'b1, 8'd3}) begin
         errors++;
         $display("FAIL rbw_old: got %b/%0d expected 1/3", adr_vld, dm_adr);
      end
      rd_en = 1; ptr = 2;
      tick();
      idle();
      vectors++;
      if ({adr_vld, dm_adr} !== {1'b1, 8'd128}) begin
         errors++;
         $display("FAIL rbw_new: got %b/%0d expected 1/128", adr_vld, dm_adr);
      end
      tick();
      vectors++;
      if ({adr_vld, ptr_err, dm_adr} !== {1'b0, 1'b0, 8'd128}) begin
         errors++;
         $display("FAIL hold: got %b/%b/%0d expected 0/0/128",
                  adr_vld, ptr_err, dm_adr);
      end
   endtask

   task automatic test_postinc();
`ifdef LUT_M_POSTINC_EN
      logic [7:0] exp_v [3] = '{8'd254, 8'd255, 8'd0};
`else
      logic [7:0] exp_v [3] = '{8'd254, 8'd254, 8'd254};
`endif
      wr_en = 1; wr_ptr = 1; wr_data = 254;
      tick();
      idle();
      for (int i = 0; i < 3; i++) begin
         rd_en = 1; inc = 1; ptr = 1;
         tick();
         vectors++;
         if ({adr_vld, dm_adr} !== {1'b1, exp_v[i]}) begin
            errors++;
            $display("FAIL postinc[%0d]: got %b/%0d expected 1/%0d",
                     i, adr_vld, dm_adr, exp_v[i]);
         end
      end
      idle();
   endtask

   task automatic test_write_wins();
      rd_en = 1; inc = 1; ptr = 3;
      wr_en = 1; wr_ptr = 3; wr_data = 64;
      tick();
      idle();
      vectors++;
      if (dm_adr !== 8'd4) begin
         errors++;
         $display("FAIL wwin_old: got %0d expected 4", dm_adr);
      end
      rd_en = 1; ptr = 3;
      tick();
      idle();
      vectors++;
      if (dm_adr !== 8'd64) begin
         errors++;
         $display("FAIL wwin_new: got %0d expected 64", dm_adr);
      end
   endtask

   task automatic test_inc_no_rd();
      inc = 1; ptr = 4;
      tick();
      idle();
      vectors++;
      if ({adr_vld, ptr_err} !== 2'b00) begin
         errors++;
         $display("FAIL inc_only_vld: got %b/%b expected 0/0",
                  adr_vld, ptr_err);
      end
      rd_en = 1; ptr = 4;
      tick();
      idle();
      vectors++;
      if (dm_adr !== 8'd5) begin
         errors++;
         $display("FAIL inc_only_val: got %0d expected 5", dm_adr);
      end
   endtask

   task automatic test_independent();
`ifdef LUT_M_POSTINC_EN
      logic [7:0] exp4 = 8'd6;
`else
      logic [7:0] exp4 = 8'd5;
`endif
      rd_en = 1; inc = 1; ptr = 4;
      wr_en = 1; wr_ptr = 6; wr_data = 99;
      tick();
      idle();
      vectors++;
      if (dm_adr !== 8'd5) begin
         errors++;
         $display("FAIL indep_rd: got %0d expected 5", dm_adr);
      end
      rd_en = 1; ptr = 4;
      tick();
      vectors++;
      if (dm_adr !== exp4) begin
         errors++;
         $display("FAIL indep_inc: got %0d expected %0d", dm_adr, exp4);
      end
      ptr = 6;
      tick();
      idle();
      vectors++;
      if (dm_adr !== 8'd99) begin
         errors++;
         $display("FAIL indep_wr: got %0d expected 99", dm_adr);
      end
   endtask

   task automatic test_wr_oob();
      wr_en = 1; wr_ptr = 8; wr_data = 11;
      tick();
      idle();
      rd_en = 1; ptr = 7;
      tick();
      vectors++;
      if ({adr_vld, ptr_err, dm_adr} !== {1'b1, 1'b0, 8'd0}) begin
         errors++;
         $display("FAIL wr_oob7: got %b/%b/%0d expected 1/0/0",
                  adr_vld, ptr_err, dm_adr);
      end
      ptr = 0;
      tick();
      idle();
      vectors++;
      if (dm_adr !== 8'd1) begin
         errors++;
         $display("FAIL wr_oob0: got %0d expected 1", dm_adr);
      end
   endtask

   task automatic test_reset_mid();
      wr_en = 1; wr_ptr = 0; wr_data = 77;
      tick();
      idle();
      rd_en = 1; ptr = 0;
      tick();
      vectors++;
      if (dm_adr !== 8'd77) begin
         errors++;
         $display("FAIL pre_rst: got %0d expected 77", dm_adr);
      end
      reset = 1; rd_en = 1; ptr = 0;
      tick();
      reset = 0; idle();
      vectors++;
      if ({adr_vld, ptr_err, dm_adr} !== {1'b0, 1'b0, 8'd0}) begin
         errors++;
         $display("FAIL rst_mid: got %b/%b/%0d expected 0/0/0",
                  adr_vld, ptr_err, dm_adr);
      end
      rd_en = 1; ptr = 0;
      tick();
      idle();
      vectors++;
      if ({adr_vld, dm_adr} !== {1'b1, 8'd1}) begin
         errors++;
         $display("FAIL post_rst: got %b/%0d expected 1/1", adr_vld, dm_adr);
      end
   endtask

   initial begin
      test_reset();
      test_defaults();
      test_oob();
      test_read_before_write();
      test_postinc();
      test_write_wins();
      test_inc_no_rd();
      test_independent();
      test_wr_oob();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
